// File: rtl/shift_reg_seq_pkg.sv
// Shared types for the shift-register sequencer: FSM state encoding and counter sizing.
// The PARITY state exists only when SHIFT_REG_SEQ_PARITY_EN is defined.
package shift_reg_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
`ifdef SHIFT_REG_SEQ_PARITY_EN
      ST_PARITY = 2'd2,
`endif
      ST_DONE   = 2'd3
   } state_t;

   // Counter must hold WIDTH-1; WIDTH=2 still needs one bit.
   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/shift_reg_sequencer_if.sv
// Bundle of the parallel-in / serial-out handshake and status signals.
// in_valid/in_ready and ser_valid/ser_ready: a transfer happens at a rising edge where both
// are high; the sender holds its data stable while valid is high and ready is low.
interface shift_reg_sequencer_if #(parameter int WIDTH = 8);

   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_ready;
   logic             abort;
   logic             busy;
   logic             done;

   modport slave (
      input  in_valid, in_data, ser_ready, abort,
      output in_ready, ser_out, ser_valid, busy, done
   );

   modport master (
      output in_valid, in_data, ser_ready, abort,
      input  in_ready, ser_out, ser_valid, busy, done
   );

endinterface

// File: rtl/shift_reg_seq_datapath.sv
// Shift register, bit counter and (with SHIFT_REG_SEQ_PARITY_EN) running parity of shifted bits.
// Driven by load/shift strobes from the sequencer FSM.
module shift_reg_seq_datapath
   import shift_reg_seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             bit_o,
   output logic             last_o
`ifdef SHIFT_REG_SEQ_PARITY_EN
   ,
   output logic             parity_o
`endif
);

   localparam int CW = cnt_width(WIDTH);

   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   assign bit_o  = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];
   assign last_o = (cnt_q == '0);

   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shreg_d = data_i;
         cnt_d   = CW'(WIDTH - 1);
      end else if (shift_i) begin
         shreg_d = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
         // Hold at zero: the FSM leaves SHIFT on the last bit, so no wrap is ever observed.
         if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SHIFT_REG_SEQ_PARITY_EN
   // XOR of every data bit sent equals even parity of the captured word once SHIFT ends.
   logic par_q, par_d;

   assign parity_o = par_q;

   always_comb begin
      par_d = par_q;
      if (load_i)       par_d = 1'b0;
      else if (shift_i) par_d = par_q ^ bit_o;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= par_d;
   end
`endif

endmodule

// File: rtl/shift_reg_sequencer.sv
// Parallel-to-serial sequencer: IDLE -> SHIFT (-> PARITY) -> DONE, with abort and async reset.
// Define SHIFT_REG_SEQ_PARITY_EN to append an even-parity bit after each word.
module shift_reg_sequencer
   import shift_reg_seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   shift_reg_sequencer_if.slave    bus,
   output state_t                  state_o
);

   state_t state_q, state_d;

   logic dp_bit;
   logic dp_last;
   logic load;
   logic shift;
`ifdef SHIFT_REG_SEQ_PARITY_EN
   logic dp_par;
`endif

   shift_reg_seq_datapath #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
   ) u_datapath (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load),
      .shift_i  (shift),
      .data_i   (bus.in_data),
      .bit_o    (dp_bit),
      .last_o   (dp_last)
`ifdef SHIFT_REG_SEQ_PARITY_EN
      ,
      .parity_o (dp_par)
`endif
   );

   assign state_o = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Abort is tested before ser_ready so it wins over a last-bit acceptance.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else if (bus.ser_ready && dp_last) begin
`ifdef SHIFT_REG_SEQ_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef SHIFT_REG_SEQ_PARITY_EN
         ST_PARITY: begin
            if (bus.abort)          state_d = ST_IDLE;
            else if (bus.ser_ready) state_d = ST_DONE;
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.ser_valid = 1'b0;
      bus.ser_out   = 1'b0;
      bus.busy      = (state_q != ST_IDLE);
      bus.done      = 1'b0;
      load          = 1'b0;
      shift         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // rst gates in_ready so nothing is offered while reset is held.
            bus.in_ready = ~rst;
            load         = ~rst & bus.in_valid;
         end
         ST_SHIFT: begin
            bus.ser_valid = 1'b1;
            bus.ser_out   = dp_bit;
            shift         = bus.ser_ready & ~bus.abort;
         end
`ifdef SHIFT_REG_SEQ_PARITY_EN
         ST_PARITY: begin
            bus.ser_valid = 1'b1;
            bus.ser_out   = dp_par;
         end
`endif
         ST_DONE: bus.done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter LSB_FIRST, default 0, meaning serial bit order (0 = MSB first, 1 = LSB first).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the parallel word is valid.
REQ-006 SHALL have port in_data, input, WIDTH bits: the parallel word.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a word.
REQ-008 SHALL have port ser_out, output, 1 bit: the current serial bit.
REQ-009 SHALL have port ser_valid, output, 1 bit: ser_out is valid.
REQ-010 SHALL have port ser_ready, input, 1 bit: the sink accepts the current bit.
REQ-011 SHALL have port abort, input, 1 bit: cancels the word in flight.
REQ-012 SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: a one-cycle pulse after the last bit of a word is accepted.

Function
REQ-014 SHALL implement the states IDLE, SHIFT, PARITY (present only with the macro) and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE with rst low; a word is accepted at an edge where in_valid&&in_ready.
REQ-016 SHALL, on acceptance: capture in_data into the shift register, load the bit counter with WIDTH-1, and enter SHIFT at the same edge.
REQ-017 SHALL, in SHIFT, present ser_valid=1 and ser_out = MSB of the register (bit 0 if LSB_FIRST).
REQ-018 SHALL, per edge with ser_valid&&ser_ready: shift by one and decrement the counter; with ser_ready low, hold ser_out and the counter unchanged, with no timeout.
REQ-019 SHALL, when the bit accepted has counter==0: go to PARITY if enabled, else to DONE.
REQ-020 SHALL, in DONE: drive done=1 and ser_valid=0 for exactly one cycle, then go to IDLE; the next word is accepted no earlier than the cycle after DONE.
REQ-021 SHALL ignore in_valid and in_data outside IDLE (no queuing).
REQ-022 SHALL, with abort high at an edge in SHIFT or PARITY: go to IDLE with no done pulse and ser_valid=0 next cycle; abort in IDLE or DONE has no effect.
REQ-023 SHALL give abort priority over a simultaneous last-bit acceptance (no done pulse).
REQ-024 SHALL give a minimum word period of WIDTH+2 cycles (WIDTH+3 with parity) with ser_ready held high.

Reset
REQ-025 SHALL, while rst is high: force state IDLE, register 0, counter 0, in_ready=0, ser_valid=0, ser_out=0, busy=0, done=0.
REQ-026 SHALL, on reset asserted mid-word: discard the word with no done pulse; first acceptance possible in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL use macro SHIFT_REG_SEQ_PARITY_EN: when defined, after the last data bit present one extra bit in PARITY with the same handshake, value = XOR of the captured word (even parity), then go to DONE.
REQ-028 SHALL, without SHIFT_REG_SEQ_PARITY_EN: not implement the PARITY state or parity logic, and go directly from the last data bit to DONE.

Structure
REQ-029 SHALL define the state enum typedef and state encodings in package shift_reg_seq_pkg.
REQ-030 SHALL place the shift register, bit counter and parity accumulator in sub-module shift_reg_seq_datapath, and the FSM in the top module.

Verification
REQ-031 SHALL cover: WIDTH=8, LSB_FIRST=0, in_data=8'hA5, ser_ready=1 -> ser_out 1,0,1,0,0,1,0,1 over 8 cycles, done pulse on the following cycle, in_ready=1 the cycle after.
REQ-032 SHALL cover: LSB_FIRST=1, in_data=8'h0F -> ser_out 1,1,1,1,0,0,0,0.
REQ-033 SHALL cover: ser_ready low 3 cycles after bit 2 of 8'hA5 -> ser_out holds 1, ser_valid stays 1, full sequence intact, done delayed by 3 cycles.
REQ-034 SHALL cover: abort at bit 4 -> ser_valid=0 next cycle, no done, busy=0, next word 8'h3C serialized correctly.
REQ-035 SHALL cover: rst pulse mid-word -> all outputs 0 immediately, in_ready=1 the cycle after deassertion; in_valid held during SHIFT -> word not captured.
REQ-036 SHALL cover, with SHIFT_REG_SEQ_PARITY_EN: 8'hA5 -> 9th bit 0; 8'h07 -> 9th bit 1; done after the 9th bit.
